// File: rtl/vga_frame_reader.sv
// VGA 640x480@60 timing generator that fetches a 320x240 window from a synchronous-read
// frame buffer and emits counters, syncs and colour aligned to the returned pixel data.
module vga_frame_reader #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int IMG_H_START = 160,
  parameter int IMG_W       = 320,
  parameter int IMG_V_START = 120,
  parameter int IMG_H       = 240,
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 17
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic              enable,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data,
  output logic [9:0]        hcounter,
  output logic [9:0]        vcounter,
  output logic              hsync,
  output logic              vsync,
  output logic              video_on,
  output logic [3:0]        r_out,
  output logic [3:0]        g_out,
  output logic [3:0]        b_out,
  output logic              frame_start
);

  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START  = H_VISIBLE + H_FP;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_VISIBLE + V_FP;
  localparam int VS_END    = VS_START + V_SYNC;
  localparam int IMG_H_END = IMG_H_START + IMG_W;
  localparam int IMG_V_END = IMG_V_START + IMG_H;

  typedef struct packed {
    logic       vld;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vis;
    logic       win;
  } stage_t;

  localparam stage_t STAGE_RST = '{vld: 1'b0, h: 10'd0, v: 10'd0,
                                   hs: 1'b1, vs: 1'b1, vis: 1'b0, win: 1'b0};

  logic [9:0]        r_h;
  logic [9:0]        r_v;
  logic [ADDR_W-1:0] r_addr;
  stage_t            r_pipe [MEM_LATENCY];

  logic   w_h_last;
  logic   w_v_last;
  logic   w_hsync;
  logic   w_vsync;
  logic   w_vis;
  logic   w_win;
  stage_t w_raw;
  stage_t w_tail;

  // Decode raw-position flags from the registered counters.
  always_comb begin
    w_h_last = (r_h == 10'(H_TOTAL - 1));
    w_v_last = (r_v == 10'(V_TOTAL - 1));
    w_hsync  = !((r_h >= 10'(HS_START)) && (r_h < 10'(HS_END)));
    w_vsync  = !((r_v >= 10'(VS_START)) && (r_v < 10'(VS_END)));
    w_vis    = (r_h < 10'(H_VISIBLE)) && (r_v < 10'(V_VISIBLE));
    w_win    = (r_h >= 10'(IMG_H_START)) && (r_h < 10'(IMG_H_END)) &&
               (r_v >= 10'(IMG_V_START)) && (r_v < 10'(IMG_V_END));
    w_raw    = '{vld: 1'b1, h: r_h, v: r_v, hs: w_hsync, vs: w_vsync, vis: w_vis, win: w_win};
  end

  // Raw h/v position; a disable parks it at the origin so timing restarts cleanly.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= 10'd0;
      r_v <= 10'd0;
    end else if (!enable) begin
      r_h <= 10'd0;
      r_v <= 10'd0;
    end else if (w_h_last) begin
      r_h <= 10'd0;
      r_v <= w_v_last ? 10'd0 : r_v + 10'd1;
    end else begin
      r_h <= r_h + 10'd1;
    end
  end

  // Linear read address: one step per window pixel, restarted at every frame boundary.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= {ADDR_W{1'b0}};
    end else if (!enable || (w_h_last && w_v_last)) begin
      r_addr <= {ADDR_W{1'b0}};
    end else if (w_win) begin
      r_addr <= r_addr + ADDR_W'(1);
    end else begin
      r_addr <= r_addr;
    end
  end

  // Alignment delay line matching the memory latency; a disable flushes every stage.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) r_pipe[i] <= STAGE_RST;
    end else if (!enable) begin
      for (int i = 0; i < MEM_LATENCY; i++) r_pipe[i] <= STAGE_RST;
    end else begin
      r_pipe[0] <= w_raw;
      for (int i = 1; i < MEM_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Output stage: colour is only taken from memory while the aligned pixel is in the window.
  always_comb begin
    w_tail   = r_pipe[MEM_LATENCY-1];
    rd_en    = w_win;
    rd_addr  = r_addr;
    hcounter = w_tail.h;
    vcounter = w_tail.v;
    hsync    = w_tail.hs;
    vsync    = w_tail.vs;
    video_on = w_tail.vis;
    if (w_tail.win) begin
      {r_out, g_out, b_out} = rd_data;
    end else begin
      {r_out, g_out, b_out} = 12'h000;
    end
    frame_start = w_tail.vld && (w_tail.h == 10'd0) && (w_tail.v == 10'd0);
  end

endmodule
